// File: rtl/ex_stage_mc_if.sv
`default_nettype none
// ============================================================================
//  Module  : ex_stage_mc_if
//  Brief   : Operand/result handshake bundle for the ex_stage_mc stage.
//  Revision: 1.0  initial release
// ============================================================================
interface ex_stage_mc_if #(
   parameter int WIDTH = 16
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] SrcData1;
   logic [WIDTH-1:0] SrcData2;
   logic [WIDTH-1:0] sextimm;
   logic             alusrc;
   logic [3:0]       aluop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] aluout;
   logic [2:0]       flag_out;

   modport master (
      output flush, in_valid, SrcData1, SrcData2, sextimm, alusrc, aluop, out_ready,
      input  in_ready, out_valid, aluout, flag_out
   );

   modport slave (
      input  flush, in_valid, SrcData1, SrcData2, sextimm, alusrc, aluop, out_ready,
      output in_ready, out_valid, aluout, flag_out
   );
endinterface
`default_nettype wire

// File: rtl/ex_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module  : ex_stage_mc
//  Brief   : Execution stage: 1-cycle ALU, iterative shift-add multiplier, NVZ flags.
//  Revision: 1.0  initial release
// ============================================================================
module ex_stage_mc #(
   parameter int WIDTH  = 16,
   parameter int SAT    = 0,
   parameter int MUL_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   ex_stage_mc_if.slave bus
);
   localparam int             CW       = $clog2(WIDTH);
   localparam int             MSB      = WIDTH - 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   aluout_q, aluout_d;
   logic [2:0]         flag_q, flag_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               in_ready, accept, is_mul;
   logic [WIDTH-1:0]   opa, opb, sum, diff, sat_val, alu_res;
   logic [CW-1:0]      shamt;
   logic [2*WIDTH-1:0] rot, step_sum;
   logic               add_ovf, sub_ovf, upd_nv, upd_z, v_new;
   logic [2:0]         alu_flags;

   assign in_ready      = !bus.flush && (state_q != S_BUSY) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && in_ready;
   assign is_mul        = (bus.aluop == 4'h8) && (MUL_EN != 0);
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.aluout    = aluout_q;
   assign bus.flag_out  = flag_q;

   always_comb begin
      opa     = bus.SrcData1;
      opb     = bus.alusrc ? bus.sextimm : bus.SrcData2;
      shamt   = opb[CW-1:0];
      sum     = opa + opb;
      diff    = opa - opb;
      add_ovf = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
      sub_ovf = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
      // Overflow direction always follows the sign of A for both ADD and SUB.
      sat_val = opa[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      rot     = {opa, opa} >> shamt;
      alu_res = opa;
      upd_nv  = 1'b0;
      upd_z   = 1'b0;
      v_new   = 1'b0;
      case (bus.aluop)
         4'd0: begin
            alu_res = ((SAT != 0) && add_ovf) ? sat_val : sum;
            v_new = add_ovf; upd_nv = 1'b1; upd_z = 1'b1;
         end
         4'd1: begin
            alu_res = ((SAT != 0) && sub_ovf) ? sat_val : diff;
            v_new = sub_ovf; upd_nv = 1'b1; upd_z = 1'b1;
         end
         4'd2: begin alu_res = opa & opb;                         upd_z = 1'b1; end
         4'd3: begin alu_res = opa | opb;                         upd_z = 1'b1; end
         4'd4: begin alu_res = opa ^ opb;                         upd_z = 1'b1; end
         4'd5: begin alu_res = opa << shamt;                      upd_z = 1'b1; end
         4'd6: begin alu_res = $unsigned($signed(opa) >>> shamt); upd_z = 1'b1; end
         4'd7: begin alu_res = rot[WIDTH-1:0];                    upd_z = 1'b1; end
         4'd8:        alu_res = '0;
         4'd9:        alu_res = opb;
         default:     alu_res = opa;
      endcase
      alu_flags[2] = upd_nv ? alu_res[MSB] : flag_q[2];
      alu_flags[1] = upd_nv ? v_new : flag_q[1];
      alu_flags[0] = upd_z ? (alu_res == '0) : flag_q[0];
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      aluout_d    = aluout_q;
      flag_d      = flag_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      step_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (bus.flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else if (state_q == S_BUSY) begin
         acc_d    = step_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            aluout_d    = step_sum[WIDTH-1:0];
            flag_d      = {step_sum[MSB], |step_sum[2*WIDTH-1:WIDTH], step_sum[WIDTH-1:0] == '0};
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
      end else if (accept) begin
         if (is_mul) begin
            mcand_d     = {{WIDTH{1'b0}}, opa};
            mplier_d    = opb;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_BUSY;
         end else begin
            aluout_d    = alu_res;
            flag_d      = alu_flags;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         aluout_q    <= '0;
         flag_q      <= 3'b000;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         aluout_q    <= aluout_d;
         flag_q      <= flag_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ex_stage_mc
//  Brief   : Randomised and directed bench for ex_stage_mc (SAT=0, SAT=1, MUL_EN=0).
//  Revision: 1.0  initial release
// ============================================================================
module tb_ex_stage_mc;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   ex_stage_mc_if #(.WIDTH(W)) b0 ();
   ex_stage_mc_if #(.WIDTH(W)) b1 ();
   ex_stage_mc_if #(.WIDTH(W)) b2 ();

   assign b1.flush = b0.flush;       assign b2.flush = b0.flush;
   assign b1.in_valid = b0.in_valid; assign b2.in_valid = b0.in_valid;
   assign b1.SrcData1 = b0.SrcData1; assign b2.SrcData1 = b0.SrcData1;
   assign b1.SrcData2 = b0.SrcData2; assign b2.SrcData2 = b0.SrcData2;
   assign b1.sextimm = b0.sextimm;   assign b2.sextimm = b0.sextimm;
   assign b1.alusrc = b0.alusrc;     assign b2.alusrc = b0.alusrc;
   assign b1.aluop = b0.aluop;       assign b2.aluop = b0.aluop;
   assign b1.out_ready = b0.out_ready; assign b2.out_ready = b0.out_ready;

   ex_stage_mc #(.WIDTH(W), .SAT(0), .MUL_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   ex_stage_mc #(.WIDTH(W), .SAT(1), .MUL_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   ex_stage_mc #(.WIDTH(W), .SAT(0), .MUL_EN(0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   // Reference state: last result and NVZ flags expected from each variant.
   logic [15:0] mr0, mr1, mr2;
   logic [2:0]  mf0, mf1, mf2;
   logic [18:0] e0, e1, e2;

   function automatic logic [18:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input bit sat,
                                          input logic [2:0] f, input bit mul_en);
      int sa, sb, full, t, s;
      logic [31:0] p;
      logic [15:0] r;
      logic n, v, z;
      sa = int'($signed(a));
      sb = int'($signed(b));
      s  = int'(b[3:0]);
      n = f[2]; v = f[1]; z = f[0]; r = a;
      case (op)
         4'd0, 4'd1: begin
            full = (op == 4'd0) ? sa + sb : sa - sb;
            t = full; r = t[15:0];
            v = (full > 32767) || (full < -32768);
            if (sat && v) r = (full > 0) ? 16'h7FFF : 16'h8000;
            n = r[15]; z = (r == 16'h0);
         end
         4'd2: begin r = a & b; z = (r == 16'h0); end
         4'd3: begin r = a | b; z = (r == 16'h0); end
         4'd4: begin r = a ^ b; z = (r == 16'h0); end
         4'd5: begin r = a << s; z = (r == 16'h0); end
         4'd6: begin t = sa >>> s; r = t[15:0]; z = (r == 16'h0); end
         4'd7: begin
            for (int i = 0; i < s; i++) r = {r[0], r[15:1]};
            z = (r == 16'h0);
         end
         4'd8: begin
            if (mul_en) begin
               p = {16'h0, a} * {16'h0, b};
               r = p[15:0]; n = r[15]; v = (p[31:16] != 16'h0); z = (r == 16'h0);
            end else begin
               r = 16'h0;
            end
         end
         4'd9:    r = b;
         default: r = a;
      endcase
      return {r, n, v, z};
   endfunction

   task automatic apply_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] bv);
      e0 = ref_op(op, a, bv, 1'b0, mf0, 1'b1);
      e1 = ref_op(op, a, bv, 1'b1, mf1, 1'b1);
      e2 = ref_op(op, a, bv, 1'b0, mf2, 1'b0);
      mr0 = e0[18:3]; mf0 = e0[2:0];
      mr1 = e1[18:3]; mf1 = e1[2:0];
      mr2 = e2[18:3]; mf2 = e2[2:0];
   endtask

   task automatic model_reset();
      mr0 = '0; mr1 = '0; mr2 = '0;
      mf0 = '0; mf1 = '0; mf2 = '0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic src);
      b0.aluop = op; b0.SrcData1 = a; b0.SrcData2 = b; b0.sextimm = imm; b0.alusrc = src;
   endtask

   // Issues one op (consuming any pending result); lat = edges after accept until out_valid.
   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic src, output int lat, output int bz);
      int t;
      @(negedge clk);
      drive(op, a, b, imm, src);
      b0.in_valid = 1'b1; b0.out_ready = 1'b1;
      t = 0; lat = 0; bz = 0;
      #1;
      while (!b0.in_ready && t < 50) begin @(negedge clk); t++; #1; end
      if (t >= 50) begin b0.in_valid = 1'b0; lat = 999; return; end
      @(posedge clk); #1;
      b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      @(negedge clk);
      while (!b0.out_valid && lat < 100) begin
         if (!b0.in_ready) bz++;
         @(posedge clk); lat++; @(negedge clk);
      end
      apply_model(op, a, src ? imm : b);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if ({b0.out_valid, b0.aluout, b0.flag_out, b0.in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1})
         $display("FAIL reset_dut0 got v=%b r=%h f=%b rdy=%b exp v=0 r=0000 f=000 rdy=1",
                  b0.out_valid, b0.aluout, b0.flag_out, b0.in_ready);
      else n_pass++;
      n_checks++;
      if ({b1.out_valid, b1.aluout, b1.flag_out, b1.in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1})
         $display("FAIL reset_dut1 got v=%b r=%h f=%b rdy=%b exp v=0 r=0000 f=000 rdy=1",
                  b1.out_valid, b1.aluout, b1.flag_out, b1.in_ready);
      else n_pass++;
      n_checks++;
      if ({b2.out_valid, b2.aluout, b2.flag_out, b2.in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1})
         $display("FAIL reset_dut2 got v=%b r=%h f=%b rdy=%b exp v=0 r=0000 f=000 rdy=1",
                  b2.out_valid, b2.aluout, b2.flag_out, b2.in_ready);
      else n_pass++;
   endtask

   task automatic test_sat_edges();
      int lat, bz;
      do_op(4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out, lat} !== {16'h8000, 3'b110, 32'd0})
         $display("FAIL add_ovf_nosat got %h/%b lat=%0d exp 8000/110 lat=0", b0.aluout, b0.flag_out, lat);
      else n_pass++;
      n_checks++;
      if ({b1.aluout, b1.flag_out} !== {16'h7FFF, 3'b010})
         $display("FAIL add_ovf_sat got %h/%b exp 7fff/010", b1.aluout, b1.flag_out);
      else n_pass++;
      do_op(4'd1, 16'h8000, 16'h0001, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out} !== {16'h7FFF, 3'b010})
         $display("FAIL sub_ovf_nosat got %h/%b exp 7fff/010", b0.aluout, b0.flag_out);
      else n_pass++;
      n_checks++;
      if ({b1.aluout, b1.flag_out} !== {16'h8000, 3'b110})
         $display("FAIL sub_ovf_sat got %h/%b exp 8000/110", b1.aluout, b1.flag_out);
      else n_pass++;
   endtask

   task automatic test_flag_retain();
      int lat, bz;
      do_op(4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, lat, bz);
      do_op(4'd2, 16'h00F0, 16'h0F00, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !== {16'h0, 3'b111, 16'h0, 3'b011})
         $display("FAIL and_keep_nv got %h/%b %h/%b exp 0000/111 0000/011",
                  b0.aluout, b0.flag_out, b1.aluout, b1.flag_out);
      else n_pass++;
      do_op(4'd9, 16'h1234, 16'h5555, 16'hFFFF, 1'b1, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !== {16'hFFFF, 3'b111, 16'hFFFF, 3'b011})
         $display("FAIL passb_imm got %h/%b %h/%b exp ffff/111 ffff/011",
                  b0.aluout, b0.flag_out, b1.aluout, b1.flag_out);
      else n_pass++;
      do_op(4'd1, 16'h0005, 16'h0005, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !== {16'h0, 3'b001, 16'h0, 3'b001})
         $display("FAIL sub_zero got %h/%b %h/%b exp 0000/001 0000/001",
                  b0.aluout, b0.flag_out, b1.aluout, b1.flag_out);
      else n_pass++;
   endtask

   task automatic test_mul();
      int lat, bz;
      do_op(4'd8, 16'h0003, 16'h0005, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if (lat !== 16 || bz !== 16)
         $display("FAIL mul_latency got lat=%0d busy=%0d exp lat=16 busy=16", lat, bz);
      else n_pass++;
      n_checks++;
      if ({b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !== {16'h000F, 3'b000, 16'h000F, 3'b000})
         $display("FAIL mul_3x5 got %h/%b %h/%b exp 000f/000", b0.aluout, b0.flag_out, b1.aluout, b1.flag_out);
      else n_pass++;
      do_op(4'd8, 16'h0100, 16'h0100, 16'h0, 1'b0, lat, bz);
      n_checks++;
      if ({b0.aluout, b0.flag_out, lat} !== {16'h0000, 3'b011, 32'd16})
         $display("FAIL mul_hi_ovf got %h/%b lat=%0d exp 0000/011 lat=16", b0.aluout, b0.flag_out, lat);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int lat, bz;
      logic [3:0] op;
      logic [15:0] a, b;
      do_op(4'd0, 16'h1234, 16'h1111, 16'h0, 1'b0, lat, bz);
      @(negedge clk);
      drive(4'd4, 16'hA5A5, 16'h0FF0, 16'h0, 1'b0);
      b0.in_valid = 1'b1; b0.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({b0.in_ready, b0.out_valid, b0.aluout, b0.flag_out} !== {1'b0, 1'b1, mr0, mf0})
            $display("FAIL stall_%0d got rdy=%b v=%b %h/%b exp rdy=0 v=1 %h/%b",
                     i, b0.in_ready, b0.out_valid, b0.aluout, b0.flag_out, mr0, mf0);
         else n_pass++;
         @(negedge clk);
      end
      b0.out_ready = 1'b1;
      #1;
      n_checks++;
      if (b0.in_ready !== 1'b1) $display("FAIL release_ready got %b exp 1", b0.in_ready);
      else n_pass++;
      @(posedge clk);
      apply_model(4'd4, 16'hA5A5, 16'h0FF0);
      for (int i = 0; i < 4; i++) begin
         op = 4'($urandom_range(0, 14));
         if (op >= 4'd8) op = op + 4'd1;
         a = pick(); b = pick();
         #1 drive(op, a, b, 16'h0, 1'b0);
         @(negedge clk);
         n_checks++;
         if ({b0.out_valid, b0.in_ready, b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !==
             {1'b1, 1'b1, mr0, mf0, mr1, mf1})
            $display("FAIL b2b_%0d got v=%b rdy=%b %h/%b %h/%b exp %h/%b %h/%b", i, b0.out_valid,
                     b0.in_ready, b0.aluout, b0.flag_out, b1.aluout, b1.flag_out, mr0, mf0, mr1, mf1);
         else n_pass++;
         @(posedge clk);
         apply_model(op, a, b);
      end
      #1 b0.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b0.out_valid, b0.aluout, b0.flag_out} !== {1'b1, mr0, mf0})
         $display("FAIL b2b_last got v=%b %h/%b exp v=1 %h/%b", b0.out_valid, b0.aluout, b0.flag_out, mr0, mf0);
      else n_pass++;
      @(posedge clk);
      #1 b0.out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b0.out_valid !== 1'b0) $display("FAIL drain_idle got v=%b exp 0", b0.out_valid);
      else n_pass++;
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      drive(4'd8, 16'h0003, 16'h0005, 16'h0, 1'b0);
      b0.in_valid = 1'b1; b0.out_ready = 1'b1;
      @(posedge clk);
      #1 b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      b0.flush = 1'b1;
      drive(4'd0, 16'h0001, 16'h0002, 16'h0, 1'b0);
      b0.in_valid = 1'b1;
      #1;
      n_checks++;
      if (b0.in_ready !== 1'b0) $display("FAIL flush_blocks_ready got %b exp 0", b0.in_ready);
      else n_pass++;
      @(posedge clk);
      #1 b0.flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b0.out_valid, b0.in_ready, b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !==
          {1'b0, 1'b1, mr0, mf0, mr1, mf1})
         $display("FAIL after_flush got v=%b rdy=%b %h/%b %h/%b exp v=0 rdy=1 %h/%b %h/%b", b0.out_valid,
                  b0.in_ready, b0.aluout, b0.flag_out, b1.aluout, b1.flag_out, mr0, mf0, mr1, mf1);
      else n_pass++;
      @(posedge clk);
      apply_model(4'd0, 16'h0001, 16'h0002);
      #1 b0.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b0.out_valid, b0.aluout, b0.flag_out} !== {1'b1, 16'h0003, 3'b000})
         $display("FAIL add_after_flush got v=%b %h/%b exp v=1 0003/000", b0.out_valid, b0.aluout, b0.flag_out);
      else n_pass++;
      b0.out_ready = 1'b1;
      @(posedge clk);
      seen = 0;
      repeat (20) begin @(negedge clk); if (b0.out_valid) seen++; end
      b0.out_ready = 1'b0;
      n_checks++;
      if (seen !== 0) $display("FAIL flush_discard got %0d stray results exp 0", seen);
      else n_pass++;
   endtask

   task automatic test_rst_mid_mul();
      int seen;
      @(negedge clk);
      drive(4'd8, 16'h00FF, 16'h00FF, 16'h0, 1'b0);
      b0.in_valid = 1'b1; b0.out_ready = 1'b1;
      @(posedge clk);
      #1 b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if ({b0.out_valid, b0.aluout, b0.flag_out, b0.in_ready, b1.out_valid, b1.aluout, b1.flag_out} !==
          {1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 16'h0, 3'b000})
         $display("FAIL rst_mid_mul got v=%b %h/%b rdy=%b v1=%b %h/%b exp v=0 0000/000 rdy=1", b0.out_valid,
                  b0.aluout, b0.flag_out, b0.in_ready, b1.out_valid, b1.aluout, b1.flag_out);
      else n_pass++;
      seen = 0;
      repeat (20) begin @(negedge clk); if (b0.out_valid || b1.out_valid) seen++; end
      n_checks++;
      if (seen !== 0) $display("FAIL rst_no_late_result got %0d exp 0", seen);
      else n_pass++;
   endtask

   task automatic test_mul_disabled();
      int lat, bz;
      test_reset();
      do_op(4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, lat, bz);
      @(negedge clk);
      drive(4'd8, 16'h0003, 16'h0005, 16'h0, 1'b0);
      b0.in_valid = 1'b1; b0.out_ready = 1'b1;
      #1;
      n_checks++;
      if (b2.in_ready !== 1'b1) $display("FAIL nomul_ready got %b exp 1", b2.in_ready);
      else n_pass++;
      @(posedge clk);
      apply_model(4'd8, 16'h0003, 16'h0005);
      #1 b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b2.out_valid, b2.aluout, b2.flag_out} !== {1'b1, 16'h0000, 3'b110})
         $display("FAIL nomul_result got v=%b %h/%b exp v=1 0000/110", b2.out_valid, b2.aluout, b2.flag_out);
      else n_pass++;
      b0.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1 b0.out_ready = 1'b0;
   endtask

   task automatic test_random();
      int lat, bz, exp_lat;
      logic [3:0] op;
      logic [15:0] a, b, imm;
      logic src;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a = pick(); b = pick(); imm = pick();
         src = 1'($urandom_range(0, 1));
         do_op(op, a, b, imm, src, lat, bz);
         exp_lat = (op == 4'd8) ? 16 : 0;
         n_checks++;
         if (lat !== exp_lat || bz !== exp_lat)
            $display("FAIL rand_lat_%0d op=%0d got lat=%0d busy=%0d exp %0d", i, op, lat, bz, exp_lat);
         else n_pass++;
         n_checks++;
         if ({b0.aluout, b0.flag_out, b1.aluout, b1.flag_out} !== {mr0, mf0, mr1, mf1})
            $display("FAIL rand_res_%0d op=%0d a=%h b=%h got %h/%b %h/%b exp %h/%b %h/%b", i, op, a,
                     src ? imm : b, b0.aluout, b0.flag_out, b1.aluout, b1.flag_out, mr0, mf0, mr1, mf1);
         else n_pass++;
      end
   endtask

   initial begin
      b0.flush = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      drive(4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      model_reset();
      test_reset();
      test_sat_edges();
      test_flag_retain();
      test_mul();
      test_backpressure();
      test_flush();
      test_rst_mid_mul();
      test_mul_disabled();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
